cpu_mem_arbiter: RTL

//  Shares one single-port unified RAM between the IF stage (fetch, read-only) and MEM stage (load/store).

---
 rtl/cpu_mem_arb_pkg.sv | 10 +
 rtl/cpu_mem_arb_lat_cnt.sv | 25 ++
 rtl/cpu_mem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cpu_mem_arb_pkg.sv
// Shared types and constants for the IF/MEM unified-RAM arbiter.
package cpu_mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} arb_state_t;
  typedef enum logic {OWN_IF, OWN_MEM} arb_owner_t;

  localparam logic [3:0] FETCH_BE = 4'hF;
  localparam int         LAT_W    = 4;

endpackage

// File: rtl/cpu_mem_arb_lat_cnt.sv
// Loadable down-counter timing the RAM read latency; stops at zero.
module cpu_mem_arb_lat_cnt
  import cpu_mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [LAT_W-1:0] value,
  output logic             zero
);

  logic [LAT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (load)
      count <= value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates one single-port RAM between fetch (IF) and load/store (MEM); MEM wins unless IF is starved.
// Optional CPU_MEM_ARB_PERF_EN adds wait/grant performance counters.
module cpu_mem_arbiter
  import cpu_mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_be,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        ram_en,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        stall_if,
  output logic        stall_mem
`ifdef CPU_MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_if_wait,
  output logic [31:0] perf_mem_wait,
  output logic [31:0] perf_grants
`endif
);

  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(MEM_LATENCY - 1);
  localparam logic [3:0]       STARVE_MX = 4'(STARVE_LIMIT);

  arb_state_t state;
  arb_owner_t owner;
  logic [3:0] starve_cnt;
  logic       any_req;
  logic       grant_if;
  logic       lat_load;
  logic       lat_zero;

  assign any_req  = if_req | mem_req;
  // IF wins only when alone or when it has lost STARVE_LIMIT contended rounds in a row.
  assign grant_if = if_req & (~mem_req | (starve_cnt == STARVE_MX));
  assign lat_load = (state == IDLE) & any_req;

  cpu_mem_arb_lat_cnt u_lat_cnt (
    .clk   (clk),
    .clr   (clr),
    .load  (lat_load),
    .value (LAT_LOAD),
    .zero  (lat_zero)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      owner      <= OWN_MEM;
      starve_cnt <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_be     <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ram_en <= 1'b0;
          if (any_req) begin
            ram_en <= 1'b1;
            state  <= WAIT;
            if (grant_if) begin
              owner      <= OWN_IF;
              starve_cnt <= '0;
              ram_we     <= 1'b0;
              ram_be     <= FETCH_BE;
              ram_addr   <= if_addr;
            end else begin
              owner     <= OWN_MEM;
              ram_we    <= mem_we;
              ram_be    <= mem_be;
              ram_addr  <= mem_addr;
              ram_wdata <= mem_wdata;
              if (if_req && starve_cnt != STARVE_MX)
                starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        WAIT: begin
          ram_en <= 1'b0;
          if (lat_zero) begin
            state <= DONE;
            if (owner == OWN_IF) begin
              if_rdata <= ram_rdata;
              if_ack   <= 1'b1;
            end else begin
              // Stores leave the previous load data visible.
              if (!ram_we)
                mem_rdata <= ram_rdata;
              mem_ack <= 1'b1;
            end
          end
        end
        DONE: begin
          ram_en  <= 1'b0;
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          ram_en <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = mem_req & ~mem_ack;

`ifdef CPU_MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      perf_if_wait  <= '0;
      perf_mem_wait <= '0;
      perf_grants   <= '0;
    end else begin
      if (stall_if)
        perf_if_wait <= perf_if_wait + 1'b1;
      if (stall_mem)
        perf_mem_wait <= perf_mem_wait + 1'b1;
      if (ram_en)
        perf_grants <= perf_grants + 1'b1;
    end
  end
`endif

endmodule
